// File: rtl/csa_tree_pkg.sv
// Shared sizing helpers for the pipelined carry-save reduction tree.
package csa_tree_pkg;

    localparam int MAX_OPS    = 9;
    localparam int MAX_LEVELS = 4;

    // Each 3:2 level turns every full group of three rows into two and keeps leftovers.
    function automatic int csa_rows_after(input int n, input int lvl);
        int rows;
        rows = n;
        for (int i = 0; i < lvl; i++) begin
            if (rows > 2) rows = (rows / 3) * 2 + rows % 3;
        end
        return rows;
    endfunction

    function automatic int csa_levels(input int n);
        int lvl;
        lvl = 0;
        for (int i = 0; i < MAX_LEVELS; i++) begin
            if (csa_rows_after(n, i) > 2) lvl = lvl + 1;
        end
        return lvl;
    endfunction

endpackage

// File: rtl/csa_tree_level.sv
// One combinational 3:2 carry-save level: groups of three rows from row 0 become
// (sum, carry<<1) pairs; one or two leftover rows pass straight through after them.
module csa_tree_level
    import csa_tree_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int ROWS_IN  = 3,
    localparam int ROWS_OUT = csa_rows_after(ROWS_IN, 1)
) (
    input  logic [ROWS_IN*WIDTH-1:0]  rows_in,
    output logic [ROWS_OUT*WIDTH-1:0] rows_out
);

    localparam int GROUPS = ROWS_IN / 3;
    localparam int LEFT   = ROWS_IN % 3;

    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
        logic [WIDTH-1:0] maj;
        assign a   = rows_in[(3*g)*WIDTH +: WIDTH];
        assign b   = rows_in[(3*g+1)*WIDTH +: WIDTH];
        assign c   = rows_in[(3*g+2)*WIDTH +: WIDTH];
        assign maj = (a & b) | (a & c) | (b & c);
        assign rows_out[(2*g)*WIDTH +: WIDTH]   = a ^ b ^ c;
        assign rows_out[(2*g+1)*WIDTH +: WIDTH] = maj << 1;
    end

    if (LEFT > 0) begin : g_left
        assign rows_out[ROWS_OUT*WIDTH-1 : 2*GROUPS*WIDTH] = rows_in[ROWS_IN*WIDTH-1 : 3*GROUPS*WIDTH];
    end

endmodule

// File: rtl/csa_tree_pipe.sv
// Elastic pipelined carry-save tree reducing NUM_OPS operands to a sum row and a carry row.
// Define CSA_TREE_CPA_EN to append a registered carry-propagate stage driving out_result.
module csa_tree_pipe
    import csa_tree_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NUM_OPS = 4,
    parameter int TAG_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_OPS*WIDTH-1:0] in_ops,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_sum,
    output logic [WIDTH-1:0]         out_carry,
    output logic [TAG_W-1:0]         out_tag,
    output logic [WIDTH-1:0]         out_result
);

    localparam int LEVELS = csa_levels(NUM_OPS);
`ifdef CSA_TREE_CPA_EN
    localparam int NSTG = LEVELS + 1;
`else
    localparam int NSTG = LEVELS;
`endif

    if (NUM_OPS < 3 || NUM_OPS > MAX_OPS) begin : g_bad_ops
        $error("csa_tree_pipe: NUM_OPS must be in 3..9");
    end

    // Handshake: a beat moves into stage i when that stage is empty or its own content
    // leaves this cycle; the ready chain is combinational so a full pipe still accepts
    // one set per cycle while out_ready is high. flush empties every stage.
    logic [NSTG-1:0]  v_q;
    logic [NSTG-1:0]  v_d;
    logic [NSTG-1:0]  adv;
    logic [NSTG-1:0]  vin;
    logic [NSTG-1:0]  load;
    logic [TAG_W-1:0] tag_q [NSTG];
    logic [TAG_W-1:0] tag_d [NSTG];

    always_comb begin
        logic blocked;
        blocked = !out_ready;
        adv     = '0;
        vin     = '0;
        for (int i = NSTG - 1; i >= 0; i--) begin
            blocked = blocked && v_q[i];
            adv[i]  = !blocked;
        end
        vin[0] = in_valid;
        for (int i = 1; i < NSTG; i++) vin[i] = v_q[i-1];
        load = adv & vin;
        v_d  = flush ? '0 : ((adv & vin) | (~adv & v_q));
    end

    always_comb begin
        tag_d[0] = load[0] ? in_tag : tag_q[0];
        for (int i = 1; i < NSTG; i++) begin
            tag_d[i] = load[i] ? tag_q[i-1] : tag_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            tag_q <= '{default: '0};
        end else begin
            v_q   <= v_d;
            tag_q <= tag_d;
        end
    end

    for (genvar s = 0; s < LEVELS; s++) begin : g_lvl
        localparam int RIN  = csa_rows_after(NUM_OPS, s);
        localparam int ROUT = csa_rows_after(NUM_OPS, s + 1);
        logic [RIN*WIDTH-1:0]  lvl_in;
        logic [ROUT*WIDTH-1:0] lvl_out;
        logic [ROUT*WIDTH-1:0] rows_d;
        logic [ROUT*WIDTH-1:0] rows_q;

        if (s == 0) begin : g_head
            assign lvl_in = in_ops;
        end else begin : g_tail
            assign lvl_in = g_lvl[s-1].rows_q;
        end

        csa_tree_level #(.WIDTH(WIDTH), .ROWS_IN(RIN)) u_level (
            .rows_in  (lvl_in),
            .rows_out (lvl_out)
        );

        always_comb begin
            rows_d = rows_q;
            if (load[s]) rows_d = lvl_out;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) rows_q <= '0;
            else        rows_q <= rows_d;
        end
    end

    // The last level always reduces three rows, so row 0 is sum and row 1 is carry.
    logic [WIDTH-1:0] csa_sum;
    logic [WIDTH-1:0] csa_carry;
    assign csa_sum   = g_lvl[LEVELS-1].rows_q[WIDTH-1:0];
    assign csa_carry = g_lvl[LEVELS-1].rows_q[2*WIDTH-1:WIDTH];

`ifdef CSA_TREE_CPA_EN
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;

    always_comb begin
        sum_d    = sum_q;
        carry_d  = carry_q;
        result_d = result_q;
        if (load[NSTG-1]) begin
            sum_d    = csa_sum;
            carry_d  = csa_carry;
            result_d = csa_sum + csa_carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q    <= '0;
            carry_q  <= '0;
            result_q <= '0;
        end else begin
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            result_q <= result_d;
        end
    end

    assign out_sum    = sum_q;
    assign out_carry  = carry_q;
    assign out_result = result_q;
`else
    assign out_sum    = csa_sum;
    assign out_carry  = csa_carry;
    assign out_result = '0;
`endif

    assign in_ready  = adv[0];
    assign out_valid = v_q[NSTG-1];
    assign out_tag   = tag_q[NSTG-1];

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Self-checking bench for csa_tree_pipe (WIDTH=8, NUM_OPS=8); honours CSA_TREE_CPA_EN.
module tb_csa_tree_pipe;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int TW = 4;
`ifdef CSA_TREE_CPA_EN
    localparam int LAT = 5;
    localparam bit CPA = 1'b1;
`else
    localparam int LAT = 4;
    localparam bit CPA = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           flush = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N*W-1:0] in_ops = '0;
    logic [TW-1:0]  in_tag = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_sum;
    logic [W-1:0]   out_carry;
    logic [TW-1:0]  out_tag;
    logic [W-1:0]   out_result;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [TW+W-1:0] exp_q[$];

    csa_tree_pipe #(.WIDTH(W), .NUM_OPS(N), .TAG_W(TW)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ops     (in_ops),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_carry  (out_carry),
        .out_tag    (out_tag),
        .out_result (out_result)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // reference model: plain modular sum of the operands
    function automatic logic [W-1:0] ref_sum(input logic [N*W-1:0] ops);
        int acc;
        acc = 0;
        for (int k = 0; k < N; k++) acc = acc + int'(ops[k*W +: W]);
        return W'(acc);
    endfunction

    function automatic logic [N*W-1:0] rand_ops();
        logic [N*W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*W +: W] = W'($urandom);
        return r;
    endfunction

    // driver: apply inputs on the falling edge, settle, then let the caller observe
    task automatic drive(input logic v, input logic [N*W-1:0] ops, input logic [TW-1:0] tag,
                         input logic rdy, input logic fl);
        @(negedge clk);
        in_valid  = v;
        in_ops    = ops;
        in_tag    = tag;
        out_ready = rdy;
        flush     = fl;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid);
        end
        total++;
        if ({out_sum, out_carry, out_result, out_tag} !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h/%h/%h/%h want=0", out_sum, out_carry, out_result, out_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [N*W-1:0] ops  [3];
        logic [W-1:0]   want [3];
        logic [W-1:0]   got;
        int t0;
        ops[0] = 64'h0000_0000_0403_0201; want[0] = 8'h0A;
        ops[1] = 64'h0000_0000_FFFF_FFFF; want[1] = 8'hFC;
        ops[2] = 64'h0000_0000_0030_2010; want[2] = 8'h60;
        for (int t = 0; t < 3; t++) begin
            drive(1'b1, ops[t], TW'(t + 5), 1'b1, 1'b0);
            t0 = cyc;
            total++;
            if (in_ready !== 1'b1) begin
                bad++; $display("FAIL directed_accept[%0d] got=%0b want=1", t, in_ready);
            end
            do drive(1'b0, '0, '0, 1'b1, 1'b0);
            while (out_valid !== 1'b1 && cyc - t0 < 20);
            got = out_sum + out_carry;
            total++;
            if (cyc - t0 != LAT) begin
                bad++; $display("FAIL directed_latency[%0d] got=%0d want=%0d", t, cyc - t0, LAT);
            end
            total++;
            if (got !== want[t]) begin
                bad++; $display("FAIL directed_sum[%0d] got=%h want=%h", t, got, want[t]);
            end
            total++;
            if (out_carry[0] !== 1'b0) begin
                bad++; $display("FAIL directed_carry_lsb[%0d] got=%0b want=0", t, out_carry[0]);
            end
            total++;
            if (out_tag !== TW'(t + 5)) begin
                bad++; $display("FAIL directed_tag[%0d] got=%h want=%h", t, out_tag, TW'(t + 5));
            end
            total++;
            if (out_result !== (CPA ? want[t] : '0)) begin
                bad++; $display("FAIL directed_result[%0d] got=%h want=%h", t, out_result, CPA ? want[t] : '0);
            end
        end
    endtask

    task automatic test_random();
        logic [N*W-1:0]  ops;
        logic [TW-1:0]   tag;
        logic            v;
        logic            hold;
        logic [W-1:0]    got;
        logic [TW+W-1:0] e;
        hold = 1'b0; v = 1'b0; ops = '0; tag = '0;
        exp_q.delete();
        for (int i = 0; i < 3000 || exp_q.size() > 0; i++) begin
            if (i >= 3100) break;
            if (!hold) begin
                v   = (i < 3000) && ($urandom_range(0, 9) < 7);
                ops = rand_ops();
                tag = TW'($urandom);
            end
            drive(v, ops, tag, (i >= 3000) || ($urandom_range(0, 9) < 7), 1'b0);
            hold = v && !in_ready;
            if (out_valid && out_ready) begin
                got = out_sum + out_carry;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL random_unexpected got=%h tag=%h", got, out_tag);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_tag, got} !== e || out_carry[0] !== 1'b0 ||
                        out_result !== (CPA ? e[W-1:0] : '0)) begin
                        bad++;
                        $display("FAIL random_result got=%h/%h res=%h c0=%0b want=%h", out_tag, got,
                                 out_result, out_carry[0], e);
                    end
                end
            end
            if (v && in_ready) exp_q.push_back({tag, ref_sum(ops)});
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL random_drain got=%0d want=0 outstanding", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [N*W-1:0]  ops;
        logic [W-1:0]    got;
        logic [TW+W-1:0] e;
        int sent, first_block, retired;
        sent = 0; first_block = -1; retired = 0;
        ops = rand_ops();
        exp_q.delete();
        for (int i = 0; i < 60 && (sent < 8 || exp_q.size() > 0); i++) begin
            drive(sent < 8, ops, TW'(sent), i >= 6, 1'b0);
            if (i < 6 && in_ready === 1'b0 && first_block < 0) first_block = sent;
            if (i == 6) begin
                total++;
                if (in_ready !== 1'b1) begin
                    bad++; $display("FAIL b2b_full_accept got=%0b want=1", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                got = out_sum + out_carry;
                retired++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL b2b_unexpected got=%h tag=%h", got, out_tag);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_tag, got} !== e) begin
                        bad++; $display("FAIL b2b_order got=%h/%h want=%h", out_tag, got, e);
                    end
                end
            end
            if (sent < 8 && in_ready) begin
                exp_q.push_back({TW'(sent), ref_sum(ops)});
                sent++;
                ops = rand_ops();
            end
        end
        total++;
        if (first_block != LAT) begin
            bad++; $display("FAIL b2b_accepts_before_stall got=%0d want=%0d", first_block, LAT);
        end
        total++;
        if (retired != 8) begin
            bad++; $display("FAIL b2b_retired got=%0d want=8", retired);
        end
    endtask

    task automatic test_flush();
        logic [N*W-1:0] ops;
        logic [W-1:0]   got;
        int t0;
        for (int i = 0; i < 3; i++) drive(1'b1, rand_ops(), TW'(i + 1), 1'b0, 1'b0);
        repeat (3) drive(1'b0, '0, '0, 1'b0, 1'b0);
        total++;
        if (out_valid !== 1'b1) begin
            bad++; $display("FAIL flush_prefill_valid got=%0b want=1", out_valid);
        end
        drive(1'b1, rand_ops(), 4'hE, 1'b0, 1'b1);
        ops = 64'h1122_3344_5566_7788;
        drive(1'b1, ops, 4'h9, 1'b1, 1'b0);
        t0 = cyc;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_out_valid got=%0b want=0", out_valid);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_in_ready got=%0b want=1", in_ready);
        end
        do drive(1'b0, '0, '0, 1'b1, 1'b0);
        while (out_valid !== 1'b1 && cyc - t0 < 20);
        got = out_sum + out_carry;
        total++;
        if ({out_tag, got} !== {4'h9, ref_sum(ops)} || cyc - t0 != LAT) begin
            bad++; $display("FAIL flush_first_output got=%h/%h lat=%0d want=9/%h lat=%0d", out_tag, got,
                            cyc - t0, ref_sum(ops), LAT);
        end
    endtask

    task automatic test_reset_mid();
        logic [N*W-1:0] ops;
        logic [W-1:0]   got;
        int t0;
        for (int i = 0; i < LAT + 2; i++) drive(1'b1, rand_ops(), TW'(i), 1'b1, 1'b0);
        total++;
        if (out_valid !== 1'b1) begin
            bad++; $display("FAIL rstmid_pre_valid got=%0b want=1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_sum !== '0 || out_carry !== '0) begin
            bad++; $display("FAIL rstmid_async_clear got=%0b/%h/%h want=0/0/0", out_valid, out_sum, out_carry);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL rstmid_in_ready got=%0b want=1", in_ready);
        end
        ops = rand_ops();
        drive(1'b1, ops, 4'h6, 1'b1, 1'b0);
        t0 = cyc;
        do drive(1'b0, '0, '0, 1'b1, 1'b0);
        while (out_valid !== 1'b1 && cyc - t0 < 20);
        got = out_sum + out_carry;
        total++;
        if ({out_tag, got} !== {4'h6, ref_sum(ops)} || cyc - t0 != LAT) begin
            bad++; $display("FAIL rstmid_fresh got=%h/%h lat=%0d want=6/%h lat=%0d", out_tag, got,
                            cyc - t0, ref_sum(ops), LAT);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
